// File: rtl/pwm_peripheral_pkg.sv
// Definitions shared by the SPI register bank and the PWM peripheral:
// register map, PWM word width and the default prescaler.
package pwm_peripheral_pkg;

  localparam logic [7:0] ADDR_EN_OUT_7_0  = 8'h00;
  localparam logic [7:0] ADDR_EN_OUT_15_8 = 8'h01;
  localparam logic [7:0] ADDR_EN_PWM_7_0  = 8'h02;
  localparam logic [7:0] ADDR_EN_PWM_15_8 = 8'h03;
  localparam logic [7:0] ADDR_PWM_DUTY    = 8'h04;

  localparam int unsigned PWM_WIDTH        = 8;
  localparam int unsigned DEFAULT_PRESCALE = 13;
  // Wide enough for the largest legal prescaler (4095).
  localparam int unsigned PRESCALE_W       = 12;
  localparam int unsigned NUM_PINS         = 16;

  typedef logic [PWM_WIDTH-1:0] pwm_word_t;
  typedef logic [NUM_PINS-1:0]  pin_vec_t;

  // Full scale is special-cased so duty 0xFF never drops low at cnt == 255.
  function automatic logic pwm_level(pwm_word_t cnt, pwm_word_t duty);
    return (duty == '1) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit period counter; flags the clk edge that ends each PWM period.
module pwm_timebase
  import pwm_peripheral_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic      clk,
  input  logic      rst_n,
  output logic      tick_o,
  output pwm_word_t pwm_cnt_o,
  output logic      period_boundary_o
);

  localparam logic [PRESCALE_W-1:0] PrescaleMax = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] prescale_cnt_d, prescale_cnt_q;
  pwm_word_t             pwm_cnt_d, pwm_cnt_q;
  logic                  tick;

  always_comb begin
    tick           = (prescale_cnt_q == PrescaleMax);
    prescale_cnt_d = tick ? '0 : prescale_cnt_q + 1'b1;
    // Natural 8-bit wrap gives the 255 -> 0 rollover.
    pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_cnt_q <= '0;
      pwm_cnt_q      <= '0;
    end else begin
      prescale_cnt_q <= prescale_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
    end
  end

  assign tick_o            = tick;
  assign pwm_cnt_o         = pwm_cnt_q;
  assign period_boundary_o = tick && (pwm_cnt_q == '1);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM output stage: duty shadow register, compare and registered per-pin mux
// (off / static high / shared PWM waveform).
module pwm_peripheral
  import pwm_peripheral_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_7_0,
  output logic [7:0] out_15_8,
  output logic       period_start
);

  logic      tick;
  logic      period_boundary;
  pwm_word_t pwm_cnt;

  pwm_word_t duty_active_d, duty_active_q;
  logic      period_start_d, period_start_q;
  pin_vec_t  out_d, out_q;
  pin_vec_t  en_out, en_pwm;
  logic      pwm_sig;

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk               (clk),
    .rst_n             (rst_n),
    .tick_o            (tick),
    .pwm_cnt_o         (pwm_cnt),
    .period_boundary_o (period_boundary)
  );

  always_comb begin
    en_out = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Shadow duty only moves at the period boundary, so mid-period writes never glitch.
    duty_active_d  = period_boundary ? pwm_duty_cycle : duty_active_q;
    period_start_d = period_boundary;

    pwm_sig = pwm_level(pwm_cnt, duty_active_q);
    // en_pwm only matters for pins whose output is enabled.
    out_d   = en_out & (~en_pwm | {NUM_PINS{pwm_sig}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_active_q  <= '0;
      period_start_q <= 1'b0;
      out_q          <= '0;
    end else begin
      duty_active_q  <= duty_active_d;
      period_start_q <= period_start_d;
      out_q          <= out_d;
    end
  end

  assign out_7_0      = out_q[7:0];
  assign out_15_8     = out_q[15:8];
  assign period_start = period_start_q;

  boundary_needs_tick_a : assert property (@(posedge clk) disable iff (!rst_n)
    period_boundary |-> tick);

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Downstream consumer of the SPI register bank. It takes the five configuration registers (output enables, PWM-mode enables, duty cycle) and drives 16 registered output pins. Each pin is forced low, held static high, or driven with a shared 8-bit PWM waveform. A prescaler sets the PWM frequency, and a shadow duty register gives glitch-free duty updates at period boundaries.

Parameters:
PRESCALE, 13, system clocks per PWM counter step; legal range 1..4095; PWM period = PRESCALE*256 clk cycles.
PWM_WIDTH, 8, PWM counter and duty width; fixed at 8 for this design.

Ports:
clk  input  1  system clock; the only clock in the block.
rst_n  input  1  asynchronous, active-low reset.
en_reg_out_7_0  input  8  per-pin output enable, pins 7..0.
en_reg_out_15_8  input  8  per-pin output enable, pins 15..8.
en_reg_pwm_7_0  input  8  per-pin PWM-mode select, pins 7..0.
en_reg_pwm_15_8  input  8  per-pin PWM-mode select, pins 15..8.
pwm_duty_cycle  input  8  requested duty; high time = duty/256 of the period, except 0xFF, which is 100%.
out_7_0  output  8  pin drive, pins 7..0 (to uo_out).
out_15_8  output  8  pin drive, pins 15..8 (to uio_out).
period_start  output  1  one-cycle pulse marking the first cycle of each PWM period.

Behaviour:
- All register inputs come from the clk domain and need no synchroniser; they are sampled every clk.
- Reset (rst_n=0, asynchronous): prescale_cnt=0, pwm_cnt=0, duty_active=0, out_7_0=0, out_15_8=0, period_start=0. Outputs go low immediately, without waiting for a clk edge.
- Prescaler: prescale_cnt counts 0..PRESCALE-1.
  - tick=1 when prescale_cnt==PRESCALE-1; the counter then wraps to 0.
  - With PRESCALE=1, tick=1 every cycle.
- Period counter: pwm_cnt increments on tick and wraps 255->0 (mod-256).
- Period boundary is the clk edge where tick=1 and pwm_cnt==255. On that edge:
  - pwm_cnt<=0.
  - duty_active<=pwm_duty_cycle.
  - period_start<=1 for exactly one cycle; it is 0 on all other cycles.
- Duty writes mid-period never affect the current period.
- The first period after reset runs with duty_active=0, so PWM pins are low for that period.
- PWM signal (combinational): pwm_sig = (duty_active==8'hFF) ? 1 : (pwm_cnt < duty_active).
  - duty 0x00 gives constant low.
  - duty 0x80 gives 50% high.
  - duty 0xFF gives constant high; no one-step low glitch.
- Pin mux, per pin i: next = en_out[i] ? (en_pwm[i] ? pwm_sig : 1) : 0.
  - en_pwm[i] is ignored when en_out[i]=0.
- Output register: out_* <= next on every clk, giving 1-cycle latency from any enable change or counter state to the pin.
- High time per period for pin i in PWM mode: duty_active*PRESCALE cycles; pin 0xFF case gives PRESCALE*256 cycles.
- Simultaneous events:
  - Enable change on a boundary edge uses the new enables with the new duty from the following cycle.
  - A duty write on the boundary edge itself is captured, because it is sampled on that edge.

Decomposition:
- Shared package/header (common with spi_peripheral):
  - register address constants ADDR_EN_OUT_7_0=0x00, ADDR_EN_OUT_15_8=0x01, ADDR_EN_PWM_7_0=0x02, ADDR_EN_PWM_15_8=0x03, ADDR_PWM_DUTY=0x04.
  - PWM_WIDTH=8.
  - default PRESCALE=13.
- Sub-module pwm_timebase: holds the prescaler and pwm_cnt, and outputs tick, pwm_cnt and period_boundary.
- pwm_peripheral itself holds the duty shadow register, the compare logic and the 16-pin mux/output register.

Test Plan:
1. Reset: hold rst_n=0 with all enables 0xFF and duty=0x80 -> out_7_0=out_15_8=0x00 and period_start=0. Deassert mid-period -> outputs stay 0x00 for the first 3328 clks; first period_start pulse at clk 3328 after release.
2. Static mode: en_reg_out_7_0=0x01, en_pwm=0x00 -> out_7_0=0x01 one clk after the write, constant thereafter; out_15_8=0x00.
3. 50% PWM: en_out_7_0=0x01, en_pwm_7_0=0x01, duty=0x80, measured from the second period -> out_7_0[0] high 1664 clks, low 1664 clks; period_start spacing exactly 3328 clks.
4. Extremes: duty=0x00 -> pin constantly 0 over a full period. duty=0xFF -> pin constantly 1 over a full period with no low cycle at pwm_cnt=255.
5. Mid-period duty change: duty 0x40 -> write 0xC0 at pwm_cnt=0x20 -> current period high 832 clks; next period high 2496 clks.
6. Upper bank + enable gating: en_out_15_8=0x80, en_pwm_15_8=0xFF, duty=0x40 -> only out_15_8[7] toggles (832 high / 2496 low). Async reset asserted mid-high -> pin low with no clk edge required.
